// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared FSM encoding and channel geometry for the mux scanner
package mux_scan_pkg;
  localparam int N_CH_C = 4;
  localparam int SEL_W = 2;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/mux_scan_if.sv
// mux_scan_if: control, mux select/return and word handshake bundle
interface mux_scan_if;
  import mux_scan_pkg::*;
  logic start;
  logic continuous;
  logic [SEL_W-1:0] sel;
  logic mux_out;
  logic [N_CH_C-1:0] data;
  logic valid;
  logic ready;
  logic busy;
  logic overrun;
  modport master(output start, continuous, mux_out, ready, input sel, data, valid, busy, overrun);
  modport slave(input start, continuous, mux_out, ready, output sel, data, valid, busy, overrun);
endinterface

// File: rtl/MUX_2.sv
// MUX_2: downstream 4:1 bit mux steered by the scanner select
module MUX_2 (
  input  logic [3:0] In,
  input  logic [1:0] Sel,
  output logic       Out
);
  assign Out = In[Sel];
endmodule

// File: rtl/mux_scan.sv
// mux_scan: steps a 4:1 mux select, dwells DWELL cycles per channel and assembles a 4-bit word
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 1,
  parameter int N_CH  = N_CH_C
) (
  input logic       clk,
  input logic       rst_n,
  mux_scan_if.slave bus
);
  logic [1:0] state;
  logic [3:0] cnt;
  logic [N_CH-1:0] shadow;
  logic [N_CH-1:0] word;
  logic tick;
  logic last;
  assign tick = state == SCAN && cnt == 4'd0;
  assign last = tick && bus.sel == 2'(N_CH - 1);
  assign bus.busy = state != IDLE;
  // word as it will look once the current channel is captured
  always_comb begin
    word = shadow;
    word[bus.sel] = bus.mux_out;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      shadow <= '0;
      bus.sel <= '0;
      bus.data <= '0;
      bus.valid <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        state <= SCAN;
        bus.sel <= '0;
        cnt <= 4'(DWELL - 1);
        bus.overrun <= 1'b0;
      end else if (state == SCAN) begin
        cnt <= tick ? 4'(DWELL - 1) : cnt - 4'd1;
        if (tick) begin
          shadow <= word;
          bus.sel <= bus.sel + 2'd1;
        end
        if (last) state <= DONE;
      end else if (state == DONE) begin
        state <= bus.continuous ? SCAN : IDLE;
        cnt <= 4'(DWELL - 1);
      end else begin
        state <= IDLE;
      end
      // a finished word lands only if the previous one is gone or leaving now
      if (last && (!bus.valid || bus.ready)) begin
        bus.data <= word;
        bus.valid <= 1'b1;
      end else if (bus.valid && bus.ready) begin
        bus.valid <= 1'b0;
      end
      if (last && bus.valid && !bus.ready) bus.overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: directed checks of the mux scanner against hand-computed words and timing
module tb_mux_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] in_a;
  logic [3:0] in_b;
  int vecs = 0;
  int errs = 0;

  mux_scan_if ia();
  mux_scan_if ib();

  always #5 clk = ~clk;

  mux_scan #(.DWELL(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  mux_scan #(.DWELL(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  MUX_2 u_ma (.In(in_a), .Sel(ia.sel), .Out(ia.mux_out));
  MUX_2 u_mb (.In(in_b), .Sel(ib.sel), .Out(ib.mux_out));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    {ia.start, ia.continuous, ia.ready, ib.start, ib.continuous, ib.ready} = '0;
    in_a = 4'd0;
    in_b = 4'd0;
    #1 rst_n = 1'b0;
    #1;
    vecs++;
    if ({ia.sel, ia.data, ia.valid, ia.busy, ia.overrun} !== 9'd0) begin
      errs++;
      $display("FAIL reset_a: got %b want 000000000", {ia.sel, ia.data, ia.valid, ia.busy, ia.overrun});
    end
    vecs++;
    if ({ib.sel, ib.data, ib.valid, ib.busy, ib.overrun} !== 9'd0) begin
      errs++;
      $display("FAIL reset_b: got %b want 000000000", {ib.sel, ib.data, ib.valid, ib.busy, ib.overrun});
    end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    vecs++;
    if ({ia.sel, ia.valid, ia.busy} !== 4'd0) begin
      errs++;
      $display("FAIL idle_after_reset: got %b want 0000", {ia.sel, ia.valid, ia.busy});
    end
  endtask

  task automatic test_basic();
    in_a = 4'b1010;
    ia.ready = 1'b1;
    ia.start = 1'b1;
    step();
    ia.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vecs++;
      if ({ia.sel, ia.valid, ia.busy} !== {2'(k), 1'b0, 1'b1}) begin
        errs++;
        $display("FAIL basic_seq%0d: got sel/valid/busy %b want %b", k, {ia.sel, ia.valid, ia.busy}, {2'(k), 1'b0, 1'b1});
      end
      step();
    end
    vecs++;
    if ({ia.sel, ia.valid, ia.busy, ia.data} !== {2'd0, 1'b1, 1'b1, 4'b1010}) begin
      errs++;
      $display("FAIL basic_word: got %b want 0011_1010", {ia.sel, ia.valid, ia.busy, ia.data});
    end
    step();
    vecs++;
    if ({ia.valid, ia.busy, ia.data} !== {1'b0, 1'b0, 4'b1010}) begin
      errs++;
      $display("FAIL basic_consume: got %b want 00_1010", {ia.valid, ia.busy, ia.data});
    end
  endtask

  task automatic test_busy_start();
    in_a = 4'b0101;
    ia.start = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      vecs++;
      if ({ia.sel, ia.valid, ia.busy} !== {2'(k), 1'b0, 1'b1}) begin
        errs++;
        $display("FAIL busy_start_seq%0d: got %b want %b", k, {ia.sel, ia.valid, ia.busy}, {2'(k), 1'b0, 1'b1});
      end
      step();
    end
    ia.start = 1'b0;
    vecs++;
    if ({ia.valid, ia.data} !== {1'b1, 4'b0101}) begin
      errs++;
      $display("FAIL busy_start_word: got %b want 1_0101", {ia.valid, ia.data});
    end
    step();
    vecs++;
    if ({ia.busy, ia.sel} !== 3'd0) begin
      errs++;
      $display("FAIL busy_start_idle: got %b want 000", {ia.busy, ia.sel});
    end
  endtask

  task automatic test_dwell3();
    logic [1:0] es;
    in_b = 4'b0110;
    ib.ready = 1'b1;
    ib.start = 1'b1;
    step();
    ib.start = 1'b0;
    for (int j = 0; j < 13; j++) begin
      es = j < 12 ? 2'(j / 3) : 2'd0;
      vecs++;
      if ({ib.sel, ib.valid, ib.busy} !== {es, j == 12, 1'b1}) begin
        errs++;
        $display("FAIL dwell3_t%0d: got %b want %b", j, {ib.sel, ib.valid, ib.busy}, {es, j == 12, 1'b1});
      end
      if (j < 12) step();
    end
    vecs++;
    if (ib.data !== 4'b0110) begin
      errs++;
      $display("FAIL dwell3_word: got %b want 0110", ib.data);
    end
    step();
    vecs++;
    if ({ib.busy, ib.valid} !== 2'b00) begin
      errs++;
      $display("FAIL dwell3_idle: got %b want 00", {ib.busy, ib.valid});
    end
  endtask

  task automatic test_overrun();
    in_a = 4'b0001;
    ia.ready = 1'b0;
    ia.continuous = 1'b1;
    ia.start = 1'b1;
    step();
    ia.start = 1'b0;
    repeat (4) step();
    vecs++;
    if ({ia.data, ia.valid, ia.overrun} !== {4'b0001, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL overrun_first: got %b want 0001_10", {ia.data, ia.valid, ia.overrun});
    end
    in_a = 4'b1111;
    repeat (5) step();
    vecs++;
    if ({ia.data, ia.valid, ia.overrun, ia.busy} !== {4'b0001, 1'b1, 1'b1, 1'b1}) begin
      errs++;
      $display("FAIL overrun_drop: got %b want 0001_111", {ia.data, ia.valid, ia.overrun, ia.busy});
    end
    ia.continuous = 1'b0;
    ia.ready = 1'b1;
    step();
    vecs++;
    if ({ia.valid, ia.overrun, ia.busy, ia.data} !== {1'b0, 1'b1, 1'b0, 4'b0001}) begin
      errs++;
      $display("FAIL overrun_consume: got %b want 010_0001", {ia.valid, ia.overrun, ia.busy, ia.data});
    end
    repeat (3) step();
    vecs++;
    if (ia.overrun !== 1'b1) begin
      errs++;
      $display("FAIL overrun_sticky: got %b want 1", ia.overrun);
    end
  endtask

  task automatic test_overrun_clear();
    ia.start = 1'b1;
    step();
    ia.start = 1'b0;
    vecs++;
    if ({ia.overrun, ia.busy} !== 2'b01) begin
      errs++;
      $display("FAIL overrun_clear: got %b want 01", {ia.overrun, ia.busy});
    end
    repeat (4) step();
    vecs++;
    if ({ia.valid, ia.data} !== {1'b1, 4'b1111}) begin
      errs++;
      $display("FAIL overrun_clear_word: got %b want 1_1111", {ia.valid, ia.data});
    end
    step();
  endtask

  task automatic test_reset_mid();
    in_a = 4'b0011;
    ia.start = 1'b1;
    step();
    ia.start = 1'b0;
    repeat (2) step();
    vecs++;
    if (ia.sel !== 2'd2) begin
      errs++;
      $display("FAIL mid_sel: got %0d want 2", ia.sel);
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({ia.sel, ia.data, ia.valid, ia.busy, ia.overrun} !== 9'd0) begin
      errs++;
      $display("FAIL mid_reset: got %b want 000000000", {ia.sel, ia.data, ia.valid, ia.busy, ia.overrun});
    end
    @(negedge clk) rst_n = 1'b1;
    in_a = 4'b1100;
    step();
    ia.start = 1'b1;
    step();
    ia.start = 1'b0;
    vecs++;
    if ({ia.sel, ia.busy} !== 3'b001) begin
      errs++;
      $display("FAIL fresh_start: got %b want 001", {ia.sel, ia.busy});
    end
    repeat (4) step();
    vecs++;
    if ({ia.valid, ia.data} !== {1'b1, 4'b1100}) begin
      errs++;
      $display("FAIL fresh_word: got %b want 1_1100", {ia.valid, ia.data});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_start();
    test_dwell3();
    test_overrun();
    test_overrun_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
